// File: rtl/dbus_sram_responder.sv
// rtl/dbus_sram_responder.sv - data-bus SRAM responder with programmable latency
//
// Purpose:
//   Responder end of the core's dbus valid/data_ok handshake. Accepts one
//   request at a time in IDLE, waits LATENCY cycles, then returns the word
//   held before the access and commits strobed bytes at the end of the
//   response cycle. Out-of-range accesses touch nothing and return err.
//
// Ports:
//   i_clk            clock, all state changes on its rising edge
//   i_reset          synchronous, active-high
//   i_dreq_valid     request valid (only looked at in IDLE)
//   i_dreq_addr      byte address; low 3 bits ignored for indexing
//   i_dreq_size      transfer size, not used (strobe selects bytes)
//   i_dreq_strobe    byte enables; zero means read
//   i_dreq_data      lane-aligned write data
//   o_dresp_addr_ok  high in the response cycle
//   o_dresp_data_ok  one-cycle completion pulse
//   o_dresp_data     word content before this access, 0 outside data_ok
//   o_err            out-of-range flag, coincident with data_ok

module dbus_sram_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dreq_valid,
  input  logic [63:0] i_dreq_addr,
  input  logic [2:0]  i_dreq_size,
  input  logic [7:0]  i_dreq_strobe,
  input  logic [63:0] i_dreq_data,
  output logic        o_dresp_addr_ok,
  output logic        o_dresp_data_ok,
  output logic [63:0] o_dresp_data,
  output logic        o_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CW    = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [IDX_W-1:0]  r_index;
  logic              r_in_range;
  logic [7:0]        r_strobe;
  logic [63:0]       r_wdata;

  logic              r_addr_ok;
  logic              r_data_ok;
  logic              r_err;
  logic [63:0]       r_rdata;

  logic [63:0]       r_mem [DEPTH_WORDS];

  logic [63:0]       w_off;
  logic              w_in_range_req;
  logic [IDX_W-1:0]  w_index_req;
  logic [IDX_W-1:0]  w_rd_index;
  logic              w_rd_in_range;
  logic              w_enter_resp;
  logic              w_unused;

  // Range check: below BASE_ADDR the subtraction wraps, so the explicit
  // compare is needed; above, any offset bit past the index field means
  // the word lies beyond the array.
  assign w_off          = i_dreq_addr - BASE_ADDR;
  assign w_in_range_req = (i_dreq_addr >= BASE_ADDR) && (w_off[63:IDX_W+3] == '0);
  assign w_index_req    = w_off[IDX_W+2:3];

  // With LATENCY=1 the response is entered straight from IDLE, so the read
  // must use the live request; otherwise the latched copy is used.
  assign w_rd_index    = (r_state == S_IDLE) ? w_index_req    : r_index;
  assign w_rd_in_range = (r_state == S_IDLE) ? w_in_range_req : r_in_range;

  assign w_enter_resp =
      ((r_state == S_IDLE) && i_dreq_valid && (LATENCY == 1)) ||
      ((r_state == S_BUSY) && (r_cnt == CW'(1)));

  assign w_unused = ^{i_dreq_size, w_off[2:0]};

  // Control FSM with registered response outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_index    <= '0;
      r_in_range <= 1'b0;
      r_strobe   <= '0;
      r_wdata    <= '0;
      r_addr_ok  <= 1'b0;
      r_data_ok  <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      // Outputs default to zero so data/err only show during data_ok.
      r_addr_ok <= 1'b0;
      r_data_ok <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;

      if (w_enter_resp) begin
        r_addr_ok <= 1'b1;
        r_data_ok <= 1'b1;
        r_err     <= ~w_rd_in_range;
        r_rdata   <= w_rd_in_range ? r_mem[w_rd_index] : 64'd0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_dreq_valid) begin
            r_index    <= w_index_req;
            r_in_range <= w_in_range_req;
            r_strobe   <= i_dreq_strobe;
            r_wdata    <= i_dreq_data;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
              r_cnt   <= '0;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == CW'(1)) begin
            r_state <= S_RESP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Byte-strobed commit at the end of the response cycle. The array has no
  // reset; a reset landing on the response cycle drops the write.
  always_ff @(posedge i_clk) begin
    if (!i_reset && (r_state == S_RESP) && r_in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (r_strobe[i]) begin
          r_mem[r_index][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign o_dresp_addr_ok = r_addr_ok;
  assign o_dresp_data_ok = r_data_ok;
  assign o_dresp_data    = r_rdata;
  assign o_err           = r_err;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb/tb_dbus_sram_responder.sv - self-checking bench for dbus_sram_responder

module tb_dbus_sram_responder;

  localparam int unsigned DEPTH  = 4096;
  localparam logic [63:0] BASE_A = 64'h8000_0000;

  logic clk;
  int   cyc;
  int   tests_run;
  int   tests_failed;
  bit   mon_en;

  logic        rst  [3];
  logic        vld  [3];
  logic [63:0] addr [3];
  logic [2:0]  size [3];
  logic [7:0]  strb [3];
  logic [63:0] wdat [3];
  logic        aok  [3];
  logic        dok  [3];
  logic [63:0] rdat [3];
  logic        err  [3];
  logic        prev_dok [3];
  int          last_ok  [3];
  int          lat_of   [3] = '{2, 1, 4};

  logic [63:0] mem [logic [63:0]];

  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE_A)) u_d0 (
    .i_clk(clk), .i_reset(rst[0]), .i_dreq_valid(vld[0]), .i_dreq_addr(addr[0]),
    .i_dreq_size(size[0]), .i_dreq_strobe(strb[0]), .i_dreq_data(wdat[0]),
    .o_dresp_addr_ok(aok[0]), .o_dresp_data_ok(dok[0]), .o_dresp_data(rdat[0]), .o_err(err[0]));

  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE_A)) u_d1 (
    .i_clk(clk), .i_reset(rst[1]), .i_dreq_valid(vld[1]), .i_dreq_addr(addr[1]),
    .i_dreq_size(size[1]), .i_dreq_strobe(strb[1]), .i_dreq_data(wdat[1]),
    .o_dresp_addr_ok(aok[1]), .o_dresp_data_ok(dok[1]), .o_dresp_data(rdat[1]), .o_err(err[1]));

  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4), .BASE_ADDR(BASE_A)) u_d2 (
    .i_clk(clk), .i_reset(rst[2]), .i_dreq_valid(vld[2]), .i_dreq_addr(addr[2]),
    .i_dreq_size(size[2]), .i_dreq_strobe(strb[2]), .i_dreq_data(wdat[2]),
    .o_dresp_addr_ok(aok[2]), .o_dresp_data_ok(dok[2]), .o_dresp_data(rdat[2]), .o_err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE_A) && (((a - BASE_A) >> 3) < 64'(DEPTH));
  endfunction

  function automatic logic [63:0] key_of(input int d, input logic [63:0] a);
    return ((a - BASE_A) >> 3) + (64'(d) << 40);
  endfunction

  // Outputs are zero whenever data_ok is low, and data_ok never lasts two cycles.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        if (!dok[d]) begin
          check("idle_data", rdat[d], 64'd0);
          check("idle_err", 64'(err[d]), 64'd0);
          check("idle_aok", 64'(aok[d]), 64'd0);
        end else begin
          check("pulse_single", 64'(prev_dok[d]), 64'd0);
        end
        prev_dok[d] = dok[d];
      end
    end
  end

  // One transaction starting at a negedge; ends at the negedge where the
  // responder is back in IDLE.
  task automatic txn(input int d, input logic [63:0] a, input logic [7:0] s,
                     input logic [63:0] w, input bit hold, input bit drop,
                     input string tag, output logic [63:0] got);
    logic [63:0] exp_d;
    logic [63:0] key;
    logic [63:0] cur;
    bit exp_e;
    bit known;
    bit seen;
    int k;
    vld[d]  = 1'b1;
    addr[d] = a;
    strb[d] = s;
    wdat[d] = w;
    size[d] = 3'($urandom_range(0, 3));
    @(posedge clk);
    exp_e = !in_rng(a);
    key   = key_of(d, a);
    known = 1'b1;
    exp_d = 64'd0;
    if (!exp_e) begin
      if (mem.exists(key)) exp_d = mem[key];
      else known = 1'b0;
    end
    seen = 1'b0;
    k = 0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      if (drop && k == 1) begin
        vld[d]  = 1'b0;
        addr[d] = a ^ 64'h18;
        wdat[d] = ~w;
        strb[d] = ~s;
      end
      if (dok[d]) seen = 1'b1;
    end
    got = rdat[d];
    check({tag, ".lat"}, 64'(k), 64'(lat_of[d]));
    if (seen) begin
      last_ok[d] = cyc;
      check({tag, ".aok"}, 64'(aok[d]), 64'd1);
      check({tag, ".err"}, 64'(err[d]), 64'(exp_e));
      if (known) check({tag, ".data"}, rdat[d], exp_d);
      if (!exp_e && s != 8'h00) begin
        if (known || s == 8'hFF) begin
          cur = known ? mem[key] : 64'd0;
          for (int i = 0; i < 8; i++)
            if (s[i]) cur[8*i +: 8] = w[8*i +: 8];
          mem[key] = cur;
        end else begin
          mem.delete(key);
        end
      end
    end
    if (!hold) vld[d] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] a;
    logic [7:0]  s;
    int t0;
    int t1;
    int n_ok;
    bit seen;
    tests_run    = 0;
    tests_failed = 0;
    mon_en       = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; vld[d] = 1'b0; addr[d] = '0; size[d] = '0;
      strb[d] = '0; wdat[d] = '0; prev_dok[d] = 1'b0; last_ok[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_aok", 64'(aok[d]), 64'd0);
      check("rst_dok", 64'(dok[d]), 64'd0);
      check("rst_data", rdat[d], 64'd0);
      check("rst_err", 64'(err[d]), 64'd0);
      rst[d] = 1'b0;
    end
    mon_en = 1'b1;

    // Randomized traffic on all three latencies against the word model.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++)
        txn(d, BASE_A + 64'(8 * i), 8'hFF, {$urandom, $urandom}, 1'b0, 1'b0, "pre", got);
      for (int n = 0; n < 25; n++) begin
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 1) == 0) a = BASE_A - 64'(8 * $urandom_range(1, 4));
          else a = BASE_A + 64'(8 * DEPTH) + 64'(8 * $urandom_range(0, 4));
        end else begin
          a = BASE_A + 64'(8 * $urandom_range(0, 7)) + 64'($urandom_range(0, 7));
        end
        s = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        txn(d, a, s, {$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)), "rand", got);
      end
    end

    // Write / read / partial strobe, LATENCY=2.
    txn(0, 64'h8000_0010, 8'hFF, 64'h1122334455667788, 1'b0, 1'b0, "wr_full", got);
    txn(0, 64'h8000_0010, 8'h00, 64'd0, 1'b0, 1'b0, "rd_full", got);
    check("rd_full.const", got, 64'h1122334455667788);
    txn(0, 64'h8000_0010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b0, 1'b0, "wr_part", got);
    txn(0, 64'h8000_0010, 8'h00, 64'd0, 1'b0, 1'b0, "rd_part", got);
    check("rd_part.const", got, 64'h11223344BBBBBBBB);

    // Out of range on both sides, then in-range content untouched.
    txn(0, 64'h8000_0000, 8'hFF, 64'h0F0E0D0C0B0A0908, 1'b0, 1'b0, "oor_pre", got);
    txn(0, 64'h7FFF_FFF8, 8'h00, 64'd0, 1'b0, 1'b0, "oor_lo", got);
    check("oor_lo.const", got, 64'd0);
    txn(0, BASE_A + 64'(8 * DEPTH), 8'h00, 64'd0, 1'b0, 1'b0, "oor_hi", got);
    check("oor_hi.const", got, 64'd0);
    txn(0, BASE_A + 64'(8 * DEPTH), 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "oor_wr", got);
    txn(0, 64'h8000_0000, 8'h00, 64'd0, 1'b0, 1'b0, "oor_chk", got);
    check("oor_chk.const", got, 64'h0F0E0D0C0B0A0908);

    // Request dropped after accept: original address and data commit.
    txn(0, 64'h8000_0028, 8'hFF, 64'h2828_2828_2828_2828, 1'b0, 1'b0, "drop_pre", got);
    txn(0, 64'h8000_0030, 8'hFF, 64'h3030_3030_3030_3030, 1'b0, 1'b1, "drop_wr", got);
    txn(0, 64'h8000_0030, 8'h00, 64'd0, 1'b0, 1'b0, "drop_rd", got);
    check("drop_rd.const", got, 64'h3030_3030_3030_3030);
    txn(0, 64'h8000_0028, 8'h00, 64'd0, 1'b0, 1'b0, "drop_other", got);
    check("drop_other.const", got, 64'h2828_2828_2828_2828);

    // Valid held through reset release: accepted only on the first low edge.
    rst[0] = 1'b1; vld[0] = 1'b1; addr[0] = 64'h8000_0028; strb[0] = 8'h00;
    repeat (2) begin
      @(negedge clk);
      check("rst_hold.dok", 64'(dok[0]), 64'd0);
    end
    rst[0] = 1'b0;
    txn(0, 64'h8000_0028, 8'h00, 64'd0, 1'b0, 1'b0, "rst_rel", got);

    // LATENCY=1 back-to-back with valid held: pulses exactly 2 cycles apart.
    for (int i = 0; i < 4; i++)
      txn(1, 64'h8000_0040 + 64'(8 * i), 8'hFF, 64'hC0DE_0000_0000_0000 + 64'(i), 1'b0, 1'b0, "b2b_pre", got);
    txn(1, 64'h8000_0040, 8'h00, 64'd0, 1'b1, 1'b0, "b2b", got);
    t0 = last_ok[1];
    for (int i = 1; i < 4; i++) begin
      txn(1, 64'h8000_0040 + 64'(8 * i), 8'h00, 64'd0, 1'b1, 1'b0, "b2b", got);
      check("b2b.own", got, 64'hC0DE_0000_0000_0000 + 64'(i));
      t1 = last_ok[1];
      check("b2b.gap", 64'(t1 - t0), 64'd2);
      t0 = t1;
    end
    vld[1] = 1'b0;

    // Reset in BUSY, LATENCY=4: no data_ok, outputs zero, write lost.
    txn(2, 64'h8000_0020, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, "rb_pre", got);
    vld[2] = 1'b1; addr[2] = 64'h8000_0020; strb[2] = 8'hFF; wdat[2] = 64'hDEAD;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst[2] = 1'b1; vld[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rb.aok", 64'(aok[2]), 64'd0);
    check("rb.dok", 64'(dok[2]), 64'd0);
    check("rb.data", rdat[2], 64'd0);
    check("rb.err", 64'(err[2]), 64'd0);
    rst[2] = 1'b0;
    n_ok = 0;
    repeat (8) begin
      @(negedge clk);
      if (dok[2]) n_ok++;
    end
    check("rb.no_dok", 64'(n_ok), 64'd0);
    txn(2, 64'h8000_0020, 8'h00, 64'd0, 1'b0, 1'b0, "rb_rd", got);
    check("rb_rd.const", got, 64'h0123_4567_89AB_CDEF);

    // Reset during the RESP cycle drops the commit.
    vld[2] = 1'b1; addr[2] = 64'h8000_0020; strb[2] = 8'hFF; wdat[2] = 64'hBEEF;
    @(posedge clk);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (dok[2]) seen = 1'b1;
    end
    check("rr.seen", 64'(seen), 64'd1);
    rst[2] = 1'b1; vld[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b0;
    txn(2, 64'h8000_0020, 8'h00, 64'd0, 1'b0, 1'b0, "rr_rd", got);
    check("rr_rd.const", got, 64'h0123_4567_89AB_CDEF);

    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Responder end of the core's data-bus valid/data_ok handshake. It accepts one `dbus_req_t` at a time, holds it for a programmable latency, then commits byte-strobed writes into an internal 64-bit-word SRAM or returns read data, signalling completion with a one-cycle `data_ok` pulse. It serves as the data-side memory model for pipeline bring-up and for multi-cycle stall testing of the core's dbus handshake logic.

## Interface
- `DEPTH_WORDS`, 4096: number of 64-bit words in the array; must be a power of two.
- `LATENCY`, 2: cycles from request acceptance to the `data_ok` cycle; must be ≥1.
- `BASE_ADDR`, 64'h8000_0000: byte address of word 0.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `dreq` in `dbus_req_t`: request bundle.
  - `valid` 1.
  - `addr` 64.
  - `size` `msize_t`.
  - `strobe` 8: byte-enable mask; all-zero means a read.
  - `data` 64: write data, already lane-aligned by the requester.
- `dresp` out `dbus_resp_t`: response bundle.
  - `addr_ok` 1.
  - `data_ok` 1.
  - `data` 64: full aligned word.
- `err` out 1: one-cycle pulse, coincident with `data_ok`, when the completed access was out of range.

## Operation
- FSM states:
  - IDLE: accept when `dreq.valid`=1 in IDLE.
  - BUSY: counting down.
  - RESP: `data_ok` cycle.
- On accept, latch `addr`, `strobe`, and `data`. `size` is ignored; strobe alone selects bytes.
- Index: `(addr - BASE_ADDR) >> 3`. The access is in range iff `addr >= BASE_ADDR` and the index is `< DEPTH_WORDS`. Low 3 address bits are ignored for indexing.
- Transitions:
  - IDLE→BUSY on accept when LATENCY>1, loading the counter with LATENCY-1.
  - IDLE→RESP on accept when LATENCY=1.
  - BUSY decrements the counter and moves to RESP when it reaches 1.
  - RESP→IDLE unconditionally.
- In RESP:
  - `dresp.data_ok`=1 and `dresp.addr_ok`=1.
  - `dresp.data` = word content before this access's write. It is 0 if out of range.
  - If `strobe`≠0 and in range, bytes with strobe[i]=1 are written at the end of the RESP cycle; other bytes are untouched.
- Out of range: no array access, `data`=0, `err`=1 in RESP.
- Once accepted, a transaction always completes. Deassertion or change of `dreq` during BUSY/RESP is ignored.
- `dreq.valid` outside IDLE is not a new request. The requester holds `valid` until `data_ok`.
- The array is not cleared by reset.
- Counter width: `$clog2(LATENCY+1)`.

## Timing
- Reset values:
  - state IDLE.
  - `dresp.addr_ok`=0, `dresp.data_ok`=0, `dresp.data`=0.
  - `err`=0.
  - counter 0.
- Request accepted at edge N (valid sampled in IDLE) → `data_ok` high during cycle N+LATENCY, for exactly one cycle.
- Earliest next accept: the edge ending the RESP cycle+1. The responder is back in IDLE the cycle after `data_ok`, so minimum issue interval is LATENCY+1 cycles.
- `dresp.data` and `err` are registered. They are valid only while `data_ok`=1 and forced to 0 otherwise.
- Read-after-write to the same word in back-to-back transactions returns the newly written bytes.
- Reset asserted in any state:
  - Next state is IDLE.
  - A pending write is dropped if reset is high during its RESP cycle.
  - No `data_ok` is produced for an aborted transaction.
- `valid` high on the same edge as reset deasserts: not accepted. Acceptance starts on the first edge with reset low.

## Test plan
- Write then read, LATENCY=2:
  - Write `addr`=0x8000_0010, `strobe`=0xFF, `data`=0x1122334455667788 → `data_ok` exactly 2 cycles after accept.
  - Read of the same address → `data`=0x1122334455667788, `err`=0.
- Partial strobe:
  - Word at 0x8000_0010 holds 0x1122334455667788; write `strobe`=0x0F, `data`=0xAAAAAAAA_BBBBBBBB.
  - Read back → 0x11223344BBBBBBBB.
- LATENCY=1 back-to-back with `valid` held continuously → `data_ok` pulses every 2 cycles, never on consecutive cycles, and each read returns the data for its own address.
- Out of range: read at 0x7FFF_FFF8 and at BASE_ADDR+8·DEPTH_WORDS → `data`=0, `err`=1 with `data_ok`. Then a write at that address followed by a read at in-range 0x8000_0000 → in-range content unchanged.
- Reset mid-operation, LATENCY=4:
  - Accept a write of 0xDEAD to 0x8000_0020, then assert reset on cycle 2 → no `data_ok`, and all outputs 0 the cycle after reset.
  - Subsequent read of 0x8000_0020 → old content.
- Request drop: after accept, deassert `valid` and change `addr` → `data_ok` still arrives at N+LATENCY, and the store commits to the originally latched address.
